fft_frame_scheduler: RTL and testbench

Frame-level controller that sequences one 8-point mixed-precision FFT core through load, compute and unload. Accepts a stream of 24-bit samples, writes them into the core's ping-pong memory through the external write port, starts the core, waits for completion, and streams the results out through the external read port. Sits between the system sample stream and the FFT core; it is the core's only master.

---
 rtl/fft_frame_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Frame controller for an 8-point FFT core: loads samples, kicks the core, unloads results.
// Optional RUN watchdog is compiled in with `define FFT_SCHED_TIMEOUT_EN.
module fft_frame_scheduler #(
  parameter int unsigned MAX_N          = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter bit          LOAD_BANK      = 1'b0,
  parameter bit          RESULT_BANK    = 1'b1,
  parameter int unsigned BITREV_IN      = 1
`ifdef FFT_SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [23:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [23:0]           out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [15:0]           frame_count,
  output logic                  core_start,
  output logic [ADDR_WIDTH-1:0] core_N,
  input  logic                  core_done,
  input  logic                  core_error,
  output logic                  ext_wr_en,
  output logic [ADDR_WIDTH-1:0] ext_wr_addr,
  output logic [23:0]           ext_wr_data,
  output logic                  ext_bank_sel,
  output logic [ADDR_WIDTH-1:0] ext_rd_addr,
  output logic                  ext_reading,
  input  logic [23:0]           core_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_KICK       = 3'd2,
    S_RUN        = 3'd3,
    S_UNLOAD_RD  = 3'd4,
    S_UNLOAD_OUT = 3'd5,
    S_FINISH     = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_N - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] idx);
    logic [ADDR_WIDTH-1:0] rev;
    rev = ZERO_IDX;
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      rev[b] = idx[ADDR_WIDTH-1-b];
    end
    return (BITREV_IN != 0) ? rev : idx;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_load_idx;
  logic [ADDR_WIDTH-1:0] r_unload_idx;
  logic [ADDR_WIDTH-1:0] w_unload_idx_next;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_err_exit;
  logic                  w_timeout;

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [23:0]           r_wr_data;
  logic                  r_bank_sel;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_reading;
  logic                  r_out_valid;
  logic [23:0]           r_out_data;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_frame_err;
  logic [15:0]           r_frame_count;
  logic                  r_core_start;

  // A load index that has wrapped back to zero inside LOAD means the frame is complete.
  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_LOAD) && (r_load_idx != ZERO_IDX));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = (r_state == S_UNLOAD_OUT) && r_out_valid && out_ready;
  assign w_err_exit = (r_state == S_RUN) && (core_error || w_timeout);

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] r_wd_cnt;

  // Watchdog counter: zero outside RUN, counts each RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= {WD_W{1'b0}};
    end else if (r_state != S_RUN) begin
      r_wd_cnt <= {WD_W{1'b0}};
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !core_done;
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode and unload index advance.
  always_comb begin
    w_next_state      = r_state;
    w_unload_idx_next = r_unload_idx;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = S_LOAD;
        else          w_next_state = S_IDLE;
      end
      S_LOAD: begin
        if (r_load_idx == ZERO_IDX) w_next_state = S_KICK;
        else                        w_next_state = S_LOAD;
      end
      S_KICK: w_next_state = S_RUN;
      S_RUN: begin
        if (core_error || w_timeout) begin
          w_next_state = S_IDLE;
        end else if (core_done) begin
          w_next_state      = S_UNLOAD_RD;
          w_unload_idx_next = ZERO_IDX;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_UNLOAD_RD: w_next_state = S_UNLOAD_OUT;
      S_UNLOAD_OUT: begin
        if (w_out_fire && (r_unload_idx == LAST_IDX)) begin
          w_next_state = S_FINISH;
        end else if (w_out_fire) begin
          w_next_state      = S_UNLOAD_RD;
          w_unload_idx_next = r_unload_idx + 1'b1;
        end else begin
          w_next_state = S_UNLOAD_OUT;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register and load/unload indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_load_idx   <= ZERO_IDX;
      r_unload_idx <= ZERO_IDX;
    end else begin
      r_state      <= w_next_state;
      r_unload_idx <= w_unload_idx_next;
      if (w_in_fire) begin
        r_load_idx <= r_load_idx + 1'b1;
      end
    end
  end

  // Registered outputs, decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en       <= 1'b0;
      r_wr_addr     <= ZERO_IDX;
      r_wr_data     <= 24'd0;
      r_bank_sel    <= LOAD_BANK;
      r_rd_addr     <= ZERO_IDX;
      r_reading     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= 24'd0;
      r_out_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 16'd0;
      r_core_start  <= 1'b0;
    end else begin
      r_wr_en      <= w_in_fire;
      r_core_start <= (w_next_state == S_KICK);
      r_reading    <= (w_next_state == S_UNLOAD_RD);
      r_out_valid  <= (w_next_state == S_UNLOAD_OUT);
      r_busy       <= (w_next_state != S_IDLE);
      r_frame_done <= (w_next_state == S_FINISH);
      r_frame_err  <= w_err_exit;
      r_bank_sel   <= ((w_next_state == S_UNLOAD_RD) || (w_next_state == S_UNLOAD_OUT)) ?
                      RESULT_BANK : LOAD_BANK;
      if (w_in_fire) begin
        r_wr_addr <= map_addr(r_load_idx);
        r_wr_data <= in_data;
      end
      if (w_next_state == S_UNLOAD_RD) begin
        r_rd_addr <= w_unload_idx_next;
      end
      // Read data is valid during UNLOAD_RD; it is held here for the whole output stall.
      if (r_state == S_UNLOAD_RD) begin
        r_out_data <= core_rd_data;
        r_out_last <= (r_unload_idx == LAST_IDX);
      end else if (w_out_fire) begin
        r_out_last <= 1'b0;
      end
      if (w_next_state == S_FINISH) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign core_N       = ADDR_WIDTH'(MAX_N);
  assign ext_wr_en    = r_wr_en;
  assign ext_wr_addr  = r_wr_addr;
  assign ext_wr_data  = r_wr_data;
  assign ext_bank_sel = r_bank_sel;
  assign ext_rd_addr  = r_rd_addr;
  assign ext_reading  = r_reading;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;
  assign frame_count  = r_frame_count;
  assign core_start   = r_core_start;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with a behavioural FFT core (done after 20 cycles,
// results = 0x100 + address).
module tb_fft_frame_scheduler;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [23:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic [15:0]   frame_count;
  logic          core_start;
  logic [AW-1:0] core_N;
  logic          core_done;
  logic          core_error;
  logic          ext_wr_en;
  logic [AW-1:0] ext_wr_addr;
  logic [23:0]   ext_wr_data;
  logic          ext_bank_sel;
  logic [AW-1:0] ext_rd_addr;
  logic          ext_reading;
  logic [23:0]   core_rd_data;

  always #5 clk = ~clk;

  fft_frame_scheduler #(
    .MAX_N(8), .ADDR_WIDTH(AW), .LOAD_BANK(1'b0), .RESULT_BANK(1'b1), .BITREV_IN(1)
`ifdef FFT_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count),
    .core_start(core_start), .core_N(core_N), .core_done(core_done), .core_error(core_error),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .ext_bank_sel(ext_bank_sel), .ext_rd_addr(ext_rd_addr), .ext_reading(ext_reading),
    .core_rd_data(core_rd_data)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: combinational read port, done/error 20 cycles after start.
  int err_mode   = 0;
  bit never_done = 1'b0;
  int run_cnt;
  assign core_rd_data = ext_reading ? (24'h000100 + {21'd0, ext_rd_addr}) : 24'hBAD0BA;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt    <= 0;
      core_done  <= 1'b0;
      core_error <= 1'b0;
    end else begin
      core_done  <= 1'b0;
      core_error <= 1'b0;
      if (core_start) begin
        run_cnt <= 20;
      end else if (run_cnt != 0) begin
        run_cnt <= run_cnt - 1;
        if (run_cnt == 1) begin
          core_done  <= (err_mode != 1) && !never_done;
          core_error <= (err_mode != 0);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr_q[$];
  logic [23:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  logic [23:0]   out_q[$];
  bit            olast_q[$];
  int            ocyc_q[$];
  int n_start = 0, start_cyc = 0, n_done = 0, done_cyc = 0, n_errp = 0, err_cyc = 0;
  bit          prev_stall;
  logic [23:0] prev_data;

  // Monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (ext_wr_en) begin
        wr_addr_q.push_back(ext_wr_addr);
        wr_data_q.push_back(ext_wr_data);
        wr_cyc_q.push_back(cyc);
        chk("wr_bank", 32'(ext_bank_sel), 32'd0);
      end
      if (ext_reading) chk("rd_bank", 32'(ext_bank_sel), 32'd1);
      chk("wr_rd_excl", 32'(ext_wr_en & ext_reading), 32'd0);
      if (core_start) begin
        n_start   <= n_start + 1;
        start_cyc <= cyc;
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        olast_q.push_back(out_last);
        ocyc_q.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      if (frame_done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (frame_err) begin
        n_errp  <= n_errp + 1;
        err_cyc <= cyc;
      end
    end
  end

  logic [AW-1:0] exp_addr [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    out_q.delete(); olast_q.delete(); ocyc_q.delete();
  endtask

  task automatic send(input logic [23:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 64) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 8; i++) send(24'(i + 1), gaps ? int'($urandom_range(0, 3)) : 0);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_wr_en", 32'(ext_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(ext_wr_addr), 32'd0);
    chk("rst_bank", 32'(ext_bank_sel), 32'd0);
    chk("rst_rd_addr", 32'(ext_rd_addr), 32'd0);
    chk("rst_reading", 32'(ext_reading), 32'd0);
    chk("core_N", 32'(core_N), 32'd0);
  endtask

  task automatic run_frame(input bit gaps, input bit stall, input int emode, input int exp_count);
    int d0, e0, s0, t;
    clear_logs();
    d0 = n_done; e0 = n_errp; s0 = n_start;
    err_mode = emode;
    send_frame(gaps);
    t = 0;
    while (n_done == d0 && n_errp == e0 && t < 400) begin
      if (stall && (t % 3 == 2)) out_ready = ~out_ready;
      @(posedge clk); #1; t++;
    end
    out_ready = 1'b1;
    chk("frame_end_seen", 32'(t < 400), 32'd1);
    chk("wr_count", 32'(wr_addr_q.size()), 32'd8);
    if (wr_addr_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("wr_addr", 32'(wr_addr_q[i]), 32'(exp_addr[i]));
        chk("wr_data", 32'(wr_data_q[i]), 32'(i + 1));
      end
      chk("start_latency", 32'(start_cyc - wr_cyc_q[7]), 32'd1);
      if (!gaps) chk("load_rate", 32'(wr_cyc_q[7] - wr_cyc_q[0]), 32'd7);
    end
    chk("start_pulses", 32'(n_start - s0), 32'd1);
    if (emode == 0) begin
      chk("out_count", 32'(out_q.size()), 32'd8);
      chk("done_pulses", 32'(n_done - d0), 32'd1);
      chk("err_pulses", 32'(n_errp - e0), 32'd0);
      if (out_q.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          chk("out_data", 32'(out_q[i]), 32'h100 + 32'(i));
          chk("out_last", 32'(olast_q[i]), 32'(i == 7));
        end
        chk("done_latency", 32'(done_cyc - ocyc_q[7]), 32'd1);
        if (!stall) chk("unload_rate", 32'(ocyc_q[7] - ocyc_q[0]), 32'd14);
      end
    end else begin
      chk("err_out_count", 32'(out_q.size()), 32'd0);
      chk("err_pulses", 32'(n_errp - e0), 32'd1);
      chk("err_no_done", 32'(n_done - d0), 32'd0);
    end
    chk("frame_count", 32'(frame_count), 32'(exp_count));
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    err_mode = 0;
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = 24'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(1'b0, 1'b0, 0, 1);
    run_frame(1'b1, 1'b1, 0, 2);
    run_frame(1'b0, 1'b0, 1, 2);
    run_frame(1'b0, 1'b0, 2, 2);

    // Reset while stalled in UNLOAD_OUT on index 3.
    clear_logs();
    send_frame(1'b0);
    t = 0;
    while (out_q.size() < 3 && t < 200) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_seen3", 32'(out_q.size()), 32'd3);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_data", 32'(out_data), 32'h103);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 0, 1);

`ifdef FFT_SCHED_TIMEOUT_EN
    begin
      int e0;
      clear_logs();
      never_done = 1'b1;
      e0 = n_errp;
      send_frame(1'b0);
      t = 0;
      while (n_errp == e0 && t < 200) begin @(posedge clk); #1; t++; end
      chk("to_err_pulse", 32'(n_errp - e0), 32'd1);
      chk("to_latency", 32'(err_cyc - start_cyc), 32'd17);
      chk("to_no_out", 32'(out_q.size()), 32'd0);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_count", 32'(frame_count), 32'd1);
      never_done = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d vectors, expected completion", n_vec);
    $fatal(1);
  end

endmodule
